// File: rtl/cpl_tlp_gen_pkg.sv
// -----------------------------------------------------------------------------
// cpl_tlp_gen_pkg: shared types and constants for the CplD TLP builder.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package cpl_tlp_gen_pkg;

  localparam int PIPE_DATA_WIDTH = 256;

  localparam logic [2:0] FMT_3DW_DATA  = 3'b010;
  localparam logic [4:0] TYPE_CPL      = 5'b01010;
  localparam logic [2:0] CPL_STATUS_SC = 3'b000;

  // Wide enough for 1024 beats, the worst case at a 32-bit beat.
  localparam int BEAT_CNT_W = 11;

  typedef struct packed {
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [6:0]  lower_addr;
    logic [11:0] byte_cnt;
    logic [9:0]  length;
  } cpl_hdr_info_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAY   = 2'd1,
    ST_DRAIN = 2'd2
  } cpl_state_e;

  // Beats needed to carry a Length field; Length 0 encodes 1024 DW.
  function automatic logic [BEAT_CNT_W-1:0] cpl_exp_beats(input logic [9:0] length,
                                                          input int dw_per_beat);
    int dw;
    dw = (length == 10'd0) ? 1024 : int'(length);
    return BEAT_CNT_W'((dw + dw_per_beat - 1) / dw_per_beat);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpl_tlp_gen.sv
// -----------------------------------------------------------------------------
// cpl_tlp_gen: pops completion descriptors and payload beats, emits CplD TLPs.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module cpl_tlp_gen
  import cpl_tlp_gen_pkg::*;
#(
  parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
  parameter int MAX_BEATS  = 1024 * 32 / DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [15:0]                       cfg_completer_id,
  input  logic                              hdr_empty,
  input  logic [$bits(cpl_hdr_info_t)-1:0]  hdr_rdata,
  output logic                              hdr_rden,
  input  logic                              pay_empty,
  input  logic [DATA_WIDTH-1:0]             pay_rdata,
  input  logic                              pay_rlast,
  output logic                              pay_rden,
  output logic                              tlp_valid,
  input  logic                              tlp_ready,
  output logic [DATA_WIDTH-1:0]             tlp_data,
  output logic                              tlp_sop,
  output logic                              tlp_eop,
  output logic                              err_len,
  output logic [15:0]                       cpl_cnt
);

  localparam int DW_PER_BEAT = DATA_WIDTH / 32;

  cpl_state_e              state_q, state_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [BEAT_CNT_W-1:0]   exp_beats_q, exp_beats_d;
  logic                    tlp_valid_q, tlp_valid_d;
  logic [DATA_WIDTH-1:0]   tlp_data_q, tlp_data_d;
  logic                    tlp_sop_q, tlp_sop_d;
  logic                    tlp_eop_q, tlp_eop_d;
  logic                    err_len_q, err_len_d;
  logic [15:0]             cpl_cnt_q, cpl_cnt_d;

  cpl_hdr_info_t           hdr;
  logic [DATA_WIDTH-1:0]   hdr_beat;
  logic                    can_load;
  logic                    hdr_pop;
  logic                    pay_pop;
  logic [BEAT_CNT_W-1:0]   cnt_inc;
  logic                    cnt_hit;

  assign hdr = cpl_hdr_info_t'(hdr_rdata);

  always_comb begin
    hdr_beat        = '0;
    hdr_beat[31:0]  = {FMT_3DW_DATA, TYPE_CPL, 14'd0, hdr.length};
    hdr_beat[63:32] = {cfg_completer_id, CPL_STATUS_SC, 1'b0, hdr.byte_cnt};
    hdr_beat[95:64] = {hdr.req_id, hdr.tag, 1'b0, hdr.lower_addr};
  end

  // The output register may take a new beat when empty or being drained this cycle.
  assign can_load = !tlp_valid_q || tlp_ready;
  assign cnt_inc  = beat_cnt_q + BEAT_CNT_W'(1);
  assign cnt_hit  = (cnt_inc == exp_beats_q);

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    exp_beats_d = exp_beats_q;
    tlp_valid_d = tlp_valid_q && !tlp_ready;
    tlp_data_d  = tlp_data_q;
    tlp_sop_d   = tlp_sop_q;
    tlp_eop_d   = tlp_eop_q;
    err_len_d   = err_len_q;
    cpl_cnt_d   = cpl_cnt_q;
    hdr_pop     = 1'b0;
    pay_pop     = 1'b0;

    if (tlp_valid_q && tlp_ready && tlp_eop_q) begin
      cpl_cnt_d = cpl_cnt_q + 16'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!hdr_empty && can_load) begin
          hdr_pop     = 1'b1;
          tlp_valid_d = 1'b1;
          tlp_data_d  = hdr_beat;
          tlp_sop_d   = 1'b1;
          tlp_eop_d   = 1'b0;
          beat_cnt_d  = '0;
          exp_beats_d = (hdr.length == 10'd0) ? BEAT_CNT_W'(MAX_BEATS)
                                              : cpl_exp_beats(hdr.length, DW_PER_BEAT);
          state_d     = ST_PAY;
        end
      end

      ST_PAY: begin
        if (!pay_empty && can_load) begin
          pay_pop     = 1'b1;
          tlp_valid_d = 1'b1;
          tlp_data_d  = pay_rdata;
          tlp_sop_d   = 1'b0;
          tlp_eop_d   = cnt_hit || pay_rlast;
          beat_cnt_d  = cnt_inc;
          if (pay_rlast) begin
            state_d = ST_IDLE;
            if (!cnt_hit) begin
              err_len_d = 1'b1;
            end
          end else if (cnt_hit) begin
            // Length satisfied but burst continues: close the TLP and discard the rest.
            err_len_d = 1'b1;
            state_d   = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (!pay_empty) begin
          pay_pop = 1'b1;
          if (pay_rlast) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      exp_beats_q <= '0;
      tlp_valid_q <= 1'b0;
      tlp_data_q  <= '0;
      tlp_sop_q   <= 1'b0;
      tlp_eop_q   <= 1'b0;
      err_len_q   <= 1'b0;
      cpl_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      exp_beats_q <= exp_beats_d;
      tlp_valid_q <= tlp_valid_d;
      tlp_data_q  <= tlp_data_d;
      tlp_sop_q   <= tlp_sop_d;
      tlp_eop_q   <= tlp_eop_d;
      err_len_q   <= err_len_d;
      cpl_cnt_q   <= cpl_cnt_d;
    end
  end

  assign hdr_rden  = rst_n && hdr_pop;
  assign pay_rden  = rst_n && pay_pop;
  assign tlp_valid = tlp_valid_q;
  assign tlp_data  = tlp_data_q;
  assign tlp_sop   = tlp_sop_q;
  assign tlp_eop   = tlp_eop_q;
  assign err_len   = err_len_q;
  assign cpl_cnt   = cpl_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpl_tlp_gen.sv
// -----------------------------------------------------------------------------
// tb_cpl_tlp_gen: scoreboard bench for cpl_tlp_gen with FWFT FIFO models.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_cpl_tlp_gen;
  import cpl_tlp_gen_pkg::*;

  localparam int DW   = 256;
  localparam int MAXB = 128;
  localparam int HW   = $bits(cpl_hdr_info_t);

  logic          clk;
  logic          rst_n;
  logic [15:0]   cfg_completer_id;
  logic          hdr_empty;
  logic [HW-1:0] hdr_rdata;
  logic          hdr_rden;
  logic          pay_empty;
  logic [DW-1:0] pay_rdata;
  logic          pay_rlast;
  logic          pay_rden;
  logic          tlp_valid;
  logic          tlp_ready;
  logic [DW-1:0] tlp_data;
  logic          tlp_sop;
  logic          tlp_eop;
  logic          err_len;
  logic [15:0]   cpl_cnt;

  cpl_tlp_gen #(.DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_completer_id(cfg_completer_id),
    .hdr_empty(hdr_empty), .hdr_rdata(hdr_rdata), .hdr_rden(hdr_rden),
    .pay_empty(pay_empty), .pay_rdata(pay_rdata), .pay_rlast(pay_rlast), .pay_rden(pay_rden),
    .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_data(tlp_data),
    .tlp_sop(tlp_sop), .tlp_eop(tlp_eop), .err_len(err_len), .cpl_cnt(cpl_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t         exp_q[$];
  cpl_hdr_info_t hq[$];
  int            hid_q[$];
  logic [DW-1:0] pq[$];
  logic          pl_q[$];
  int            pid_q[$];

  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  logic model_err = 1'b0;
  int   cyc = 0;
  int   sop_cyc = 0;
  int   last_cyc = 0;
  int   tlp_id = 0;
  int   tmp_id;
  logic hpop_f = 1'b0;
  logic ppop_f = 1'b0;
  logic stall_prev = 1'b0;
  logic [DW-1:0] held_data;
  logic [1:0]    held_se;
  beat_t         b;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // FWFT FIFO heads, refreshed just after the falling edge.
  always @(negedge clk) begin
    #1;
    hdr_empty = (hq.size() == 0);
    hdr_rdata = (hq.size() != 0) ? HW'(hq[0]) : '0;
    pay_empty = (pq.size() == 0);
    pay_rdata = (pq.size() != 0) ? pq[0] : '0;
    pay_rlast = (pq.size() != 0) ? pl_q[0] : 1'b0;
  end

  always @(posedge clk) begin
    if (ppop_f) begin
      if (pq.size() != 0) begin
        void'(pq.pop_front());
        void'(pl_q.pop_front());
        void'(pid_q.pop_front());
      end
    end
    if (hpop_f) begin
      if (hq.size() != 0) begin
        void'(hq.pop_front());
        tmp_id = hid_q.pop_front();
        chk("hdr_after_drain", DW'(pid_q.size() == 0 || pid_q[0] == tmp_id), DW'(1));
      end
    end
    hpop_f = 1'b0;
    ppop_f = 1'b0;
  end

  // Output monitor and scoreboard compare.
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (hdr_rden) chk("hdr_rden_nonempty", DW'(hdr_empty), DW'(0));
      if (pay_rden) chk("pay_rden_nonempty", DW'(pay_empty), DW'(0));
      hpop_f = hdr_rden;
      ppop_f = pay_rden;
      if (stall_prev) begin
        chk("stall_valid", DW'(tlp_valid), DW'(1));
        chk("stall_data", tlp_data, held_data);
        chk("stall_sop_eop", DW'({tlp_sop, tlp_eop}), DW'(held_se));
      end
      stall_prev = 1'b0;
      if (tlp_valid && !tlp_ready) begin
        chk("stall_pay_rden", DW'(pay_rden), DW'(0));
        stall_prev = 1'b1;
        held_data  = tlp_data;
        held_se    = {tlp_sop, tlp_eop};
      end
      if (tlp_valid && tlp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", DW'(1), DW'(0));
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", tlp_data, b.data);
          chk("beat_sop", DW'(tlp_sop), DW'(b.sop));
          chk("beat_eop", DW'(tlp_eop), DW'(b.eop));
          if (b.eop) model_cnt++;
          if (b.sop) sop_cyc = cyc;
          last_cyc = cyc;
        end
      end
    end else begin
      hpop_f     = 1'b0;
      ppop_f     = 1'b0;
      stall_prev = 1'b0;
    end
  end

  function automatic logic [DW-1:0] hdr_beat(input cpl_hdr_info_t h);
    logic [DW-1:0] v;
    v        = '0;
    v[31:0]  = {3'b010, 5'b01010, 14'd0, h.length};
    v[63:32] = {cfg_completer_id, 3'b000, 1'b0, h.byte_cnt};
    v[95:64] = {h.req_id, h.tag, 1'b0, h.lower_addr};
    return v;
  endfunction

  // Queue one completion: header, n payload beats, and its expected TLP beats.
  task automatic send_cpl(input logic [9:0] len, input int n, input bit rl, input bit pat);
    cpl_hdr_info_t h;
    int            exp_b;
    int            emit;
    logic [DW-1:0] d;
    beat_t         e;
    h.req_id     = 16'($urandom);
    h.tag        = 8'($urandom);
    h.lower_addr = 7'($urandom);
    h.byte_cnt   = 12'($urandom);
    h.length     = len;
    exp_b = (len == 10'd0) ? MAXB : (int'(len) * 32 + DW - 1) / DW;
    emit  = (n < exp_b) ? n : exp_b;
    tlp_id++;
    hq.push_back(h);
    hid_q.push_back(tlp_id);
    e.data = hdr_beat(h); e.sop = 1'b1; e.eop = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      d = pat ? {32{8'hA5}} : {$urandom, $urandom, $urandom, $urandom,
                               $urandom, $urandom, $urandom, $urandom};
      pq.push_back(d);
      pl_q.push_back(rl && (i == n - 1));
      pid_q.push_back(tlp_id);
      if (i < emit) begin
        e.data = d;
        e.sop  = 1'b0;
        e.eop  = (i == emit - 1) && (rl || emit == exp_b);
        exp_q.push_back(e);
      end
    end
    if (rl && n != exp_b) model_err = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      #4;
      done = (exp_q.size() == 0) && (hq.size() == 0) && (pq.size() == 0) && !tlp_valid;
    end
    chk({tag, "_timeout"}, DW'(!done), DW'(0));
    chk({tag, "_cpl_cnt"}, DW'(cpl_cnt), DW'(model_cnt));
    chk({tag, "_err_len"}, DW'(err_len), DW'(model_err));
  endtask

  initial begin
    rst_n            = 1'b0;
    tlp_ready        = 1'b1;
    cfg_completer_id = 16'hBEEF;
    hdr_empty        = 1'b1;
    hdr_rdata        = '0;
    pay_empty        = 1'b1;
    pay_rdata        = '0;
    pay_rlast        = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("rst_valid", DW'(tlp_valid), DW'(0));
    chk("rst_cpl_cnt", DW'(cpl_cnt), DW'(0));
    chk("rst_err_len", DW'(err_len), DW'(0));

    // 1: single-beat completion, header latency and DW0 encoding
    @(negedge clk);
    send_cpl(10'd8, 1, 1'b1, 1'b1);
    @(negedge clk);
    #4;
    chk("hdr_latency", DW'(tlp_valid && tlp_sop), DW'(1));
    chk("hdr_dw0", DW'(tlp_data[31:0]), DW'(32'h4A00_0008));
    wait_done("t1");

    // 2: backpressure on payload beat 2
    @(negedge clk);
    send_cpl(10'd20, 3, 1'b1, 1'b0);
    for (int i = 0; i < 200 && exp_q.size() > 2; i++) begin
      @(negedge clk);
      #4;
    end
    @(negedge clk);
    tlp_ready = 1'b0;
    repeat (3) @(negedge clk);
    tlp_ready = 1'b1;
    wait_done("t2");

    // 3: Length=0 is 1024 DW, back-to-back payload
    @(negedge clk);
    send_cpl(10'd0, MAXB, 1'b1, 1'b0);
    wait_done("t3");
    chk("t3_back_to_back", DW'(last_cyc - sop_cyc), DW'(MAXB));

    // 4: early rlast, then a normal completion
    @(negedge clk);
    send_cpl(10'd16, 1, 1'b1, 1'b0);
    send_cpl(10'd8, 1, 1'b1, 1'b0);
    wait_done("t4");

    // 5: late rlast forces a drain before the next header
    @(negedge clk);
    send_cpl(10'd8, 3, 1'b1, 1'b0);
    send_cpl(10'd24, 1, 1'b1, 1'b0);
    wait_done("t5");

    // 6: reset while waiting for payload
    @(negedge clk);
    send_cpl(10'd20, 1, 1'b0, 1'b0);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #4;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete(); hq.delete(); hid_q.delete();
    pq.delete(); pl_q.delete(); pid_q.delete();
    model_cnt = 0;
    model_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("t6_rst_outs", DW'({tlp_valid, tlp_sop, tlp_eop, err_len, hdr_rden, pay_rden}), DW'(0));
    chk("t6_rst_data", tlp_data, DW'(0));
    chk("t6_rst_cnt", DW'(cpl_cnt), DW'(0));
    @(negedge clk);
    send_cpl(10'd8, 1, 1'b1, 1'b0);
    wait_done("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpl_tlp_gen.md
Name: cpl_tlp_gen

Overview:
TX-side completion builder, directly downstream of the RX completion-data handler. It pops one completion header descriptor from cpl_hdr_fifo and the matching 32B payload beats from cpl_pay_fifo, and emits a CplD TLP beat stream (header beat, then payload beats) toward the TX data-link arbiter. It checks that the payload beat count matches the header Length field and recovers from mismatches without wedging the pipe.

Parameters:
DATA_WIDTH, PCIE_PKG::PIPE_DATA_WIDTH (256), payload and TLP beat width in bits; must be a multiple of 32.
MAX_BEATS, 1024*32/DATA_WIDTH (128), beats for Length=0, which encodes 1024 DW.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
cfg_completer_id  in  16  static completer bus/dev/fn
hdr_empty  in  1  cpl_hdr_fifo empty (FWFT)
hdr_rdata  in  $bits(cpl_hdr_info_t)  head descriptor {req_id[15:0], tag[7:0], lower_addr[6:0], byte_cnt[11:0], length[9:0]}
hdr_rden  out  1  pop descriptor
pay_empty  in  1  cpl_pay_fifo empty (FWFT)
pay_rdata  in  DATA_WIDTH  head payload beat
pay_rlast  in  1  head beat is last of its burst
pay_rden  out  1  pop payload beat
tlp_valid  out  1  output beat valid
tlp_ready  in  1  downstream accepts beat
tlp_data  out  DATA_WIDTH  TLP beat
tlp_sop  out  1  first beat of TLP
tlp_eop  out  1  last beat of TLP
err_len  out  1  sticky payload/Length mismatch flag
cpl_cnt  out  16  count of TLPs whose eop beat was accepted; wraps

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; all outputs 0; beat counter 0. Reset mid-TLP aborts silently. FIFOs are reset by their owner.
- Output register: tlp_* registered. The register loads when (!tlp_valid || tlp_ready) and the state has a beat to send. While tlp_valid=1 && tlp_ready=0, tlp_data, tlp_sop and tlp_eop hold stable.
- hdr_rden and pay_rden are combinational pulses in the same cycle the popped word loads. They are never asserted when the matching empty=1.
- exp_beats = (length==0) ? MAX_BEATS : ceil(length*32/DATA_WIDTH). It is latched at header pop.
- States:
  - IDLE: if !hdr_empty and the output register can load, pop the header and load the header beat (sop=1, eop=0). Go to PAY.
  - PAY: if !pay_empty and the register can load, pop a beat, load tlp_data=pay_rdata, and increment beat_cnt.
    - eop = (beat_cnt+1==exp_beats) || pay_rlast.
    - If eop and pay_rlast: go to IDLE.
    - Early rlast (pay_rlast with beat_cnt+1<exp_beats): set err_len, go to IDLE.
    - Count reached without rlast: set err_len, go to DRAIN.
  - DRAIN: pop payload beats whenever !pay_empty, emit nothing, and go to IDLE on the beat with pay_rlast.
- Header beat layout:
  - DW0 is in tlp_data[31:0], DW1 in [63:32], DW2 in [95:64], bits above 95 are zero. Each DW uses PCIe spec bit numbering.
  - DW0: [31:29]=3'b010, [28:24]=5'b01010, TC/attr=0, [9:0]=length.
  - DW1: [31:16]=cfg_completer_id, [15:13]=status 000, [12]=BCM 0, [11:0]=byte_cnt.
  - DW2: [31:16]=req_id, [15:8]=tag, [7]=0, [6:0]=lower_addr.
- Latency: header at FIFO head with idle output register gives tlp_valid next cycle. With tlp_ready=1 throughout, payload beats follow back-to-back (one per clk). A new header may load in the cycle after the previous eop loads.
- cpl_cnt increments on tlp_valid && tlp_ready && tlp_eop.
- err_len clears only on reset.
- Payload and header are never interleaved across TLPs.

Decomposition:
- PCIE_PKG: cpl_hdr_info_t packed struct; FMT_3DW_DATA=3'b010; TYPE_CPL=5'b01010; CPL_STATUS_SC=3'b000; function cpl_exp_beats(length).
- Single module. The output register is inline; no sub-module is warranted.

Test Plan:
1. Length=8, one payload beat 0xA5.., rlast=1, tlp_ready=1: header beat DW0=0x4A000008, sop=1, eop=0. Next cycle the payload beat appears with eop=1. cpl_cnt=1, err_len=0.
2. Length=20, 3 beats, tlp_ready low for 3 cycles on beat 2: beat 2 data is held stable, pay_rden=0 during the stall, 4 beats total, eop on beat 3.
3. Length=0, 128 payload beats, rlast on beat 128: 129 TLP beats, eop only on the last one, err_len=0.
4. Early rlast, Length=16, rlast on beat 1: TLP is 2 beats with eop on payload beat 1, err_len=1. The next queued header is sent normally.
5. Late rlast, Length=8, FIFO holds 3 beats with rlast on beat 3: eop on payload beat 1, beats 2–3 are popped without output, err_len=1. The next header is not popped until the drain completes.
6. rst_n=0 for one cycle mid-PAY: next cycle all outputs are 0 and state is IDLE. A fresh Length=8 completion afterwards produces a correct 2-beat TLP.
